counter_loader: RTL

Upstream job feeder for `up_counter`. Accepts 4-bit count values over a valid/ready interface and buffers them in a small FIFO. For each value it issues a one-cycle `load` with `val` to the counter, then waits for the counter's `R` flag to rise. It reports each completion, or a timeout, to the controller, so the dynamic-adder control path can queue several delays back-to-back.

---
 rtl/counter_loader.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/counter_loader.sv
// Generic FIFO: circular buffer with occupancy count; head is visible combinationally.
// Latency: a push at edge k is readable at dout from edge k onward (one edge after being written).
// Backpressure: push is ignored while full; pop is ignored while empty.
module fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & (count != '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// Job feeder for up_counter: queues count values, loads each one, waits for a fresh R rise or a timeout.
// Latency: push at edge k -> cnt_load high between edges k+1 and k+2; done/timeout pulse the cycle after detection.
// Backpressure: in_ready is FIFO not-full (registered occupancy); values offered while full are ignored.
module counter_loader #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_val,
  output logic [WIDTH-1:0]             cnt_val,
  output logic                         cnt_load,
  input  logic                         cnt_r,
  output logic                         done_valid,
  output logic [WIDTH-1:0]             done_val,
  output logic                         timeout_err,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   pending
);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ARM, S_WAIT} state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] head;
  logic            full, pop, cnt_r_q, rise, fire_done, fire_to;
  logic [TW-1:0]   timer;

  fifo #(.W(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .din   (in_val),
    .pop   (pop),
    .dout  (head),
    .count (pending),
    .full  (full)
  );

  assign in_ready = ~full;
  assign rise     = cnt_r & ~cnt_r_q;
  assign cnt_load = (state == S_LOAD);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // A rise seen on the last timer cycle still counts as completion.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    fire_done = 1'b0;
    fire_to   = 1'b0;
    case (state)
      S_IDLE: begin
        if (pending != '0) begin
          pop       = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: state_nxt = S_ARM;
      S_ARM:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (rise) begin
          fire_done = 1'b1;
          state_nxt = S_IDLE;
        end else if (timer == TW'(TIMEOUT-1)) begin
          fire_to   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r_q     <= 1'b0;
      done_valid  <= 1'b0;
      timeout_err <= 1'b0;
      cnt_val     <= '0;
      done_val    <= '0;
      timer       <= '0;
    end else begin
      cnt_r_q     <= cnt_r;
      done_valid  <= fire_done;
      timeout_err <= fire_to;
      if (pop) begin
        cnt_val  <= head;
        done_val <= head;
      end
      if (state == S_ARM)
        timer <= '0;
      else if (state == S_WAIT && !fire_done && !fire_to)
        timer <= timer + TW'(1);
    end
  end
endmodule
